// File: rtl/mem_access.sv
`timescale 1ns/1ps
// mem_access: memory-access stage sitting between execute and register-file
// writeback.
//
// It latches one execute result. It runs a request/acknowledge transaction
// to data memory for loads and stores, with byte-lane steering for stores
// and shifting plus extension for loads. It then emits a single writeback beat.
//
// Optional build macro: MEM_MISALIGN_TRAP_EN
//   defined   - a misaligned access skips the bus and returns the faulting
//               address with misalign=1 and no register write.
//   undefined - misalign is always 0. Half accesses use only off[1] and
//               word accesses ignore the offset, so the naturally aligned
//               lanes are used.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   in_valid / in_ready   execute handshake; in_ready is high only when idle
//   alu_result, w_data    effective address or plain value, and store data
//   mem_access_width      00 byte, 01 half, 10/11 word
//   is_load_unsigned      1 = zero-extend load, 0 = sign-extend
//   is_load, is_store     access type; both high is handled as a load
//   rd_addr, reg_write    destination register and write intent
//   dmem_*                data-memory request/acknowledge bus
//   out_valid, wb_*       one-cycle writeback beat
//   misalign              misaligned-access flag, pulses with out_valid
module mem_access #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       w_data,
  input  logic [1:0]        mem_access_width,
  input  logic              is_load_unsigned,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [RD_W-1:0]   rd_addr,
  input  logic              reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              out_valid,
  output logic [31:0]       wb_data,
  output logic [RD_W-1:0]   wb_rd_addr,
  output logic              wb_reg_write,
  output logic              misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t state_r, state_nxt_s;

  logic              accept_s, mem_op_s, is_store_eff_s, is_byte_s, is_half_s;
  logic              trap_s, wb_en_s;
  logic [1:0]        off_s, eff_off_s;
  logic [3:0]        wstrb_s;
  logic [31:0]       wdata_s, addr_ext_s, shifted_s, load_data_s;

  logic              in_ready_r, dmem_req_r, dmem_we_r, out_valid_r;
  logic              wb_reg_write_r, misalign_r, wb_en_r;
  logic              is_byte_r, is_half_r, unsigned_r;
  logic [1:0]        eff_off_r;
  logic [ADDR_W-1:0] dmem_addr_r;
  logic [31:0]       dmem_wdata_r, wb_data_r;
  logic [3:0]        dmem_wstrb_r;
  logic [RD_W-1:0]   wb_rd_addr_r;

  // Decode of the incoming execute result: access type, lanes and trap
  always_comb begin
    accept_s       = (state_r == ST_IDLE) && in_valid;
    mem_op_s       = is_load || is_store;
    is_store_eff_s = is_store && !is_load;
    is_byte_s      = (mem_access_width == 2'b00);
    is_half_s      = (mem_access_width == 2'b01);
    off_s          = alu_result[1:0];
    addr_ext_s     = 32'h0000_0000;
    addr_ext_s[ADDR_W-1:0] = alu_result[ADDR_W-1:0];

    // Lane offset actually used: halves snap to their natural halfword,
    // words always start at lane 0.
    if (is_byte_s) begin
      eff_off_s = off_s;
      wdata_s   = {4{w_data[7:0]}};
    end else if (is_half_s) begin
      eff_off_s = {off_s[1], 1'b0};
      wdata_s   = {2{w_data[15:0]}};
    end else begin
      eff_off_s = 2'b00;
      wdata_s   = w_data;
    end

    if (!is_store_eff_s) begin
      wstrb_s = 4'b0000;
    end else if (is_byte_s) begin
      wstrb_s = 4'b0001 << off_s;
    end else if (is_half_s) begin
      wstrb_s = off_s[1] ? 4'b1100 : 4'b0011;
    end else begin
      wstrb_s = 4'b1111;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    trap_s = mem_op_s &&
             ((is_half_s && off_s[0]) ||
              (!is_byte_s && !is_half_s && (off_s != 2'b00)));
`else
    trap_s = 1'b0;
`endif

    wb_en_s = reg_write && !is_store_eff_s && (rd_addr != '0) && !trap_s;
  end

  // Load formatting from the latched lane offset, width and sign mode
  always_comb begin
    shifted_s = dmem_rdata >> {eff_off_r, 3'b000};
    if (is_byte_r) begin
      load_data_s = unsigned_r ? {24'h00_0000, shifted_s[7:0]}
                               : {{24{shifted_s[7]}}, shifted_s[7:0]};
    end else if (is_half_r) begin
      load_data_s = unsigned_r ? {16'h0000, shifted_s[15:0]}
                               : {{16{shifted_s[15]}}, shifted_s[15:0]};
    end else begin
      load_data_s = shifted_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; acks outside BUS are ignored
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (mem_op_s && !trap_s) ? ST_BUS : ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (dmem_ack) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BUS;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered outputs, bus drive and per-transaction latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r     <= 1'b1;
      dmem_req_r     <= 1'b0;
      dmem_we_r      <= 1'b0;
      dmem_addr_r    <= '0;
      dmem_wdata_r   <= 32'h0000_0000;
      dmem_wstrb_r   <= 4'b0000;
      out_valid_r    <= 1'b0;
      wb_data_r      <= 32'h0000_0000;
      wb_rd_addr_r   <= '0;
      wb_reg_write_r <= 1'b0;
      misalign_r     <= 1'b0;
      wb_en_r        <= 1'b0;
      eff_off_r      <= 2'b00;
      is_byte_r      <= 1'b0;
      is_half_r      <= 1'b0;
      unsigned_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            in_ready_r   <= 1'b0;
            wb_rd_addr_r <= rd_addr;
            wb_en_r      <= wb_en_s;
            eff_off_r    <= eff_off_s;
            is_byte_r    <= is_byte_s;
            is_half_r    <= is_half_s;
            unsigned_r   <= is_load_unsigned;
            if (mem_op_s && !trap_s) begin
              dmem_req_r   <= 1'b1;
              dmem_we_r    <= is_store_eff_s;
              dmem_addr_r  <= {alu_result[ADDR_W-1:2], 2'b00};
              dmem_wdata_r <= wdata_s;
              dmem_wstrb_r <= wstrb_s;
            end else begin
              // Plain result or trapped access: straight to writeback
              out_valid_r    <= 1'b1;
              wb_data_r      <= trap_s ? addr_ext_s : alu_result;
              wb_reg_write_r <= wb_en_s;
              misalign_r     <= trap_s;
            end
          end
        end
        ST_BUS: begin
          if (dmem_ack) begin
            dmem_req_r     <= 1'b0;
            dmem_we_r      <= 1'b0;
            dmem_wstrb_r   <= 4'b0000;
            dmem_wdata_r   <= 32'h0000_0000;
            out_valid_r    <= 1'b1;
            wb_data_r      <= load_data_s;
            wb_reg_write_r <= wb_en_r;
          end
        end
        ST_RESP: begin
          out_valid_r    <= 1'b0;
          wb_reg_write_r <= 1'b0;
          misalign_r     <= 1'b0;
          in_ready_r     <= 1'b1;
        end
        default: begin
          out_valid_r <= 1'b0;
          dmem_req_r  <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_r;
  assign dmem_req     = dmem_req_r;
  assign dmem_we      = dmem_we_r;
  assign dmem_addr    = dmem_addr_r;
  assign dmem_wdata   = dmem_wdata_r;
  assign dmem_wstrb   = dmem_wstrb_r;
  assign out_valid    = out_valid_r;
  assign wb_data      = wb_data_r;
  assign wb_rd_addr   = wb_rd_addr_r;
  assign wb_reg_write = wb_reg_write_r;
  assign misalign     = misalign_r;

endmodule

// File: tb/tb_mem_access.sv
`timescale 1ns/1ps
// Self-checking bench for mem_access: directed scenarios plus randomized
// operations checked against a behavioural model of the stage.
module tb_mem_access;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready;
  logic [31:0] alu_result, w_data;
  logic [1:0]  mem_access_width;
  logic        is_load_unsigned, is_load, is_store, reg_write;
  logic [4:0]  rd_addr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        out_valid, wb_reg_write, misalign;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd_addr;

  int checks = 0;
  int errors = 0;

  mem_access #(.ADDR_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .w_data(w_data), .mem_access_width(mem_access_width),
    .is_load_unsigned(is_load_unsigned), .is_load(is_load), .is_store(is_store),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .out_valid(out_valid), .wb_data(wb_data),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu; logic [31:0] wd; logic [1:0] width;
    logic uns; logic ld; logic st; logic [4:0] rd; logic rw;
  } op_t;

  typedef struct {
    int latency; int req_cycles; int ready_low; int ov_cycles;
    bit ready_at_start; bit unstable; bit timeout;
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb;
    logic [31:0] wb; logic [4:0] wrd; logic wbe; logic mis;
  } obs_t;

  typedef struct {
    int latency; int req_cycles; bit is_mem; bit is_st; bit check_wb;
    logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;
    logic [31:0] wb; logic wbe; logic mis;
  } exp_t;

  // Behavioural reference: what the stage should produce for one operation.
  function automatic exp_t model(input op_t op, input int delay, input logic [31:0] rdata);
    exp_t e;
    int unsigned off, sz, lane;
    logic [31:0] val;
    bit st, mem, mis;
    st   = op.st && !op.ld;
    mem  = op.ld || op.st;
    off  = op.alu % 4;
    sz   = (op.width == 2'd0) ? 1 : (op.width == 2'd1) ? 2 : 4;
    mis  = mem && TRAP && ((sz == 2 && (off % 2) == 1) || (sz == 4 && off != 0));
    e.is_mem     = mem && !mis;
    e.is_st      = st;
    e.mis        = mis;
    e.latency    = e.is_mem ? delay + 1 : 1;
    e.req_cycles = e.is_mem ? delay : 0;
    e.addr       = op.alu - off;
    e.wbe        = op.rw && !st && (op.rd != 5'd0) && !mis;
    e.check_wb   = !(e.is_mem && st);
    if (sz == 1) begin
      e.strb  = 4'(1 << off);
      e.wdata = (op.wd & 32'hFF) * 32'h0101_0101;
    end else if (sz == 2) begin
      e.strb  = (off >= 2) ? 4'hC : 4'h3;
      e.wdata = (op.wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      e.strb  = 4'hF;
      e.wdata = op.wd;
    end
    if (!e.is_mem) begin
      e.wb = op.alu;
    end else begin
      lane = (sz == 1) ? off : (sz == 2) ? (off / 2) * 2 : 0;
      val  = rdata >> (8 * lane);
      if (sz == 1) begin
        val = val & 32'hFF;
        if (!op.uns && val >= 32'd128) val = val - 32'd256;
      end else if (sz == 2) begin
        val = val & 32'hFFFF;
        if (!op.uns && val >= 32'd32768) val = val - 32'd65536;
      end
      e.wb = val;
    end
    return e;
  endfunction

  // Drives one operation starting at a negedge, plays the memory with the
  // given ack delay (ack in the delay-th request cycle) and records outputs.
  task automatic drive_op(input op_t op, input int delay, input logic [31:0] rdata,
                          output obs_t ob);
    int cyc;
    bit done, seen_ov;
    ob = '{default: 0};
    ob.ready_at_start = in_ready;
    in_valid = 1'b1; alu_result = op.alu; w_data = op.wd;
    mem_access_width = op.width; is_load_unsigned = op.uns;
    is_load = op.ld; is_store = op.st; rd_addr = op.rd; reg_write = op.rw;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_result = $urandom; w_data = $urandom; rd_addr = 5'($urandom);
    cyc = 0; done = 0; seen_ov = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (!in_ready) ob.ready_low++;
      if (dmem_req) begin
        ob.req_cycles++;
        if (ob.req_cycles == 1) begin
          ob.addr = dmem_addr; ob.we = dmem_we; ob.wdata = dmem_wdata; ob.strb = dmem_wstrb;
        end else if (dmem_addr !== ob.addr || dmem_we !== ob.we ||
                     dmem_wdata !== ob.wdata || dmem_wstrb !== ob.strb) begin
          ob.unstable = 1;
        end
        if (ob.req_cycles == delay) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      if (out_valid) begin
        ob.ov_cycles++;
        if (!seen_ov) begin
          ob.latency = cyc; ob.wb = wb_data; ob.wrd = wb_rd_addr;
          ob.wbe = wb_reg_write; ob.mis = misalign;
        end
        seen_ov = 1;
      end
      if (seen_ov && in_ready) done = 1;
      if (cyc >= 60) begin
        ob.timeout = 1; done = 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; w_data = '0;
    mem_access_width = 2'b00; is_load_unsigned = 1'b0; is_load = 1'b0;
    is_store = 1'b0; rd_addr = '0; reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++;
    if ({dmem_req, dmem_we, dmem_wstrb, out_valid, wb_reg_write, misalign} !== 9'b0) begin
      errors++; $display("FAIL reset_ctrl got req=%b we=%b strb=%b ov=%b wbe=%b mis=%b exp all 0",
                         dmem_req, dmem_we, dmem_wstrb, out_valid, wb_reg_write, misalign);
    end
    checks++;
    if ({dmem_addr, dmem_wdata, wb_data, wb_rd_addr} !== 101'b0) begin
      errors++; $display("FAIL reset_data got addr=%h wdata=%h wb=%h rd=%0d exp all 0",
                         dmem_addr, dmem_wdata, wb_data, wb_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nonmem();
    op_t op; obs_t ob;
    op = '{alu: 32'h1234_5678, wd: 32'h0, width: 2'b10, uns: 1'b0, ld: 1'b0, st: 1'b0, rd: 5'd5, rw: 1'b1};
    drive_op(op, 1, 32'h0, ob);
    checks++;
    if (ob.timeout || ob.latency != 1) begin errors++; $display("FAIL nonmem_latency got %0d exp 1", ob.latency); end
    checks++;
    if (ob.wb !== 32'h1234_5678 || ob.wrd !== 5'd5 || ob.wbe !== 1'b1) begin
      errors++; $display("FAIL nonmem_wb got %h rd=%0d wbe=%b exp 12345678 rd=5 wbe=1", ob.wb, ob.wrd, ob.wbe);
    end
    checks++;
    if (ob.req_cycles != 0) begin errors++; $display("FAIL nonmem_req got %0d cycles exp 0", ob.req_cycles); end
  endtask

  task automatic test_byte_load();
    op_t op; obs_t ob;
    op = '{alu: 32'h0000_1003, wd: 32'h0, width: 2'b00, uns: 1'b0, ld: 1'b1, st: 1'b0, rd: 5'd7, rw: 1'b1};
    drive_op(op, 3, 32'h80AA_BBCC, ob);
    checks++;
    if (ob.addr !== 32'h0000_1000 || ob.req_cycles != 3 || ob.we !== 1'b0 || ob.strb !== 4'b0000) begin
      errors++; $display("FAIL sbyte_bus got addr=%h req=%0d we=%b strb=%b exp 1000 3 0 0000",
                         ob.addr, ob.req_cycles, ob.we, ob.strb);
    end
    checks++;
    if (ob.wb !== 32'hFFFF_FF80 || ob.latency != 4) begin
      errors++; $display("FAIL sbyte_wb got %h lat=%0d exp ffffff80 lat=4", ob.wb, ob.latency);
    end
    op.uns = 1'b1;
    drive_op(op, 3, 32'h80AA_BBCC, ob);
    checks++;
    if (ob.wb !== 32'h0000_0080) begin errors++; $display("FAIL ubyte_wb got %h exp 00000080", ob.wb); end
  endtask

  task automatic test_store_half();
    op_t op; obs_t ob;
    op = '{alu: 32'h0000_2002, wd: 32'hDEAD_BEEF, width: 2'b01, uns: 1'b0, ld: 1'b0, st: 1'b1, rd: 5'd3, rw: 1'b1};
    drive_op(op, 2, 32'h0, ob);
    checks++;
    if (ob.we !== 1'b1 || ob.strb !== 4'b1100 || ob.wdata !== 32'hBEEF_BEEF || ob.addr !== 32'h0000_2000) begin
      errors++; $display("FAIL shalf_bus got we=%b strb=%b wdata=%h addr=%h exp 1 1100 beefbeef 2000",
                         ob.we, ob.strb, ob.wdata, ob.addr);
    end
    checks++;
    if (ob.wbe !== 1'b0 || ob.timeout) begin errors++; $display("FAIL shalf_wbe got %b exp 0", ob.wbe); end
  endtask

  task automatic test_back_to_back();
    op_t op; obs_t ob;
    logic [31:0] rd_val;
    rd_val = $urandom;
    op = '{alu: 32'h0000_4000, wd: 32'h0, width: 2'b10, uns: 1'b0, ld: 1'b1, st: 1'b0, rd: 5'd9, rw: 1'b1};
    drive_op(op, 1, rd_val, ob);
    checks++;
    if (ob.latency != 2 || ob.ready_low != 2 || ob.ov_cycles != 1) begin
      errors++; $display("FAIL b2b_zero_wait got lat=%0d low=%0d ov=%0d exp 2 2 1",
                         ob.latency, ob.ready_low, ob.ov_cycles);
    end
    checks++;
    if (ob.wb !== rd_val) begin errors++; $display("FAIL b2b_word_wb got %h exp %h", ob.wb, rd_val); end
    op = '{alu: 32'hCAFE_0001, wd: 32'h0, width: 2'b00, uns: 1'b0, ld: 1'b0, st: 1'b0, rd: 5'd1, rw: 1'b1};
    drive_op(op, 1, 32'h0, ob);
    checks++;
    if (ob.ready_at_start !== 1'b1 || ob.latency != 1 || ob.wb !== 32'hCAFE_0001) begin
      errors++; $display("FAIL b2b_second got ready=%b lat=%0d wb=%h exp 1 1 cafe0001",
                         ob.ready_at_start, ob.latency, ob.wb);
    end
  endtask

  task automatic test_misalign();
    op_t op; obs_t ob;
    logic [31:0] rd_val;
    rd_val = $urandom;
    op = '{alu: 32'h0000_3001, wd: 32'h0, width: 2'b10, uns: 1'b0, ld: 1'b1, st: 1'b0, rd: 5'd4, rw: 1'b1};
    drive_op(op, 2, rd_val, ob);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++;
    if (ob.req_cycles != 0 || ob.mis !== 1'b1 || ob.wb !== 32'h0000_3001 || ob.wbe !== 1'b0) begin
      errors++; $display("FAIL misalign_trap got req=%0d mis=%b wb=%h wbe=%b exp 0 1 00003001 0",
                         ob.req_cycles, ob.mis, ob.wb, ob.wbe);
    end
`else
    checks++;
    if (ob.addr !== 32'h0000_3000 || ob.req_cycles != 2 || ob.mis !== 1'b0 || ob.wb !== rd_val) begin
      errors++; $display("FAIL misalign_plain got addr=%h req=%0d mis=%b wb=%h exp 3000 2 0 %h",
                         ob.addr, ob.req_cycles, ob.mis, ob.wb, rd_val);
    end
`endif
  endtask

  task automatic test_reset_mid_bus();
    int bad;
    obs_t ob;
    op_t op;
    in_valid = 1'b1; alu_result = 32'h0000_5000; mem_access_width = 2'b10;
    is_load = 1'b1; is_store = 1'b0; rd_addr = 5'd6; reg_write = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL midbus_req_before got %b exp 1", dmem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midbus_reset got req=%b rdy=%b ov=%b exp 0 1 0", dmem_req, in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    dmem_ack = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stray_ack got %0d bad cycles exp 0", bad); end
    op = '{alu: 32'h0000_0042, wd: 32'h0, width: 2'b00, uns: 1'b0, ld: 1'b0, st: 1'b0, rd: 5'd2, rw: 1'b1};
    drive_op(op, 1, 32'h0, ob);
    checks++;
    if (ob.latency != 1 || ob.wb !== 32'h0000_0042) begin
      errors++; $display("FAIL after_reset_op got lat=%0d wb=%h exp 1 00000042", ob.latency, ob.wb);
    end
  endtask

  task automatic test_random();
    op_t op; obs_t ob; exp_t ex;
    int delay;
    logic [31:0] rd_val;
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind   = $urandom_range(0, 3);
      op.alu = $urandom; op.wd = $urandom; op.width = 2'($urandom_range(0, 3));
      op.uns = 1'($urandom); op.ld = (kind == 1 || kind == 3); op.st = (kind == 2 || kind == 3);
      op.rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom); op.rw = 1'($urandom);
      delay  = $urandom_range(1, 4);
      rd_val = $urandom;
      ex = model(op, delay, rd_val);
      drive_op(op, delay, rd_val, ob);
      checks++;
      if (ob.timeout || ob.latency != ex.latency || ob.ready_low != ex.latency || ob.ov_cycles != 1) begin
        errors++; $display("FAIL rnd_timing i=%0d got lat=%0d low=%0d ov=%0d to=%0d exp lat=%0d",
                           i, ob.latency, ob.ready_low, ob.ov_cycles, ob.timeout, ex.latency);
      end
      checks++;
      if (ob.req_cycles != ex.req_cycles || ob.unstable) begin
        errors++; $display("FAIL rnd_req i=%0d got %0d unstable=%0d exp %0d", i, ob.req_cycles, ob.unstable, ex.req_cycles);
      end
      if (ex.is_mem) begin
        checks++;
        if (ob.addr !== ex.addr || ob.we !== ex.is_st || ob.strb !== (ex.is_st ? ex.strb : 4'b0000)) begin
          errors++; $display("FAIL rnd_bus i=%0d got addr=%h we=%b strb=%b exp %h %b %b",
                             i, ob.addr, ob.we, ob.strb, ex.addr, ex.is_st, ex.is_st ? ex.strb : 4'b0000);
        end
        if (ex.is_st) begin
          checks++;
          if (ob.wdata !== ex.wdata) begin errors++; $display("FAIL rnd_wdata i=%0d got %h exp %h", i, ob.wdata, ex.wdata); end
        end
      end
      if (ex.check_wb) begin
        checks++;
        if (ob.wb !== ex.wb) begin errors++; $display("FAIL rnd_wb i=%0d got %h exp %h", i, ob.wb, ex.wb); end
      end
      checks++;
      if (ob.wrd !== op.rd || ob.wbe !== ex.wbe || ob.mis !== ex.mis) begin
        errors++; $display("FAIL rnd_wbctl i=%0d got rd=%0d wbe=%b mis=%b exp %0d %b %b",
                           i, ob.wrd, ob.wbe, ob.mis, op.rd, ex.wbe, ex.mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_byte_load();
    test_store_half();
    test_back_to_back();
    test_misalign();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (effective address or plain value), store data, access width and the load-sign flag.
- Runs the request/acknowledge transaction to data memory, with byte-lane steering and load extension.
- Hands a single writeback beat to the register-file write stage.
- Stalls upstream via in_ready while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte address width; alu_result bits above ADDR_W are ignored.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute result valid this cycle.
- in_ready  out  1  stage can accept; high only in IDLE.
- alu_result  in  32  ALU value / effective byte address.
- w_data  in  32  store data (unshifted, low-aligned).
- mem_access_width  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- is_load_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- is_load  in  1  instruction is a load.
- is_store  in  1  instruction is a store; is_load and is_store both high is illegal (treated as load).
- rd_addr  in  RD_W  destination register.
- reg_write  in  1  instruction writes rd.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 00).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte write strobes; 0000 on reads.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  transaction complete.
- out_valid  out  1  one-cycle writeback beat.
- wb_data  out  32  writeback value.
- wb_rd_addr  out  RD_W  writeback register.
- wb_reg_write  out  1  writeback enable; qualified by out_valid.
- misalign  out  1  misaligned-access flag, pulses with out_valid.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0 except in_ready, which is 1.
  - An asserted rst_n mid-transaction drops dmem_req immediately and abandons the transaction; a later stray dmem_ack in IDLE is ignored.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Accept when in_valid and in_ready; all inputs are latched at that edge N.
  - Non-memory op: go to RESP; wb_data = alu_result.
  - Load or store: go to BUS.
- BUS:
  - dmem_req is high from cycle N+1 and stays high, with addr/we/wdata/wstrb stable, until dmem_ack is sampled.
  - dmem_ack may be high in the first BUS cycle (minimum 1-cycle memory).
  - On ack: capture and format rdata; dmem_req deasserts at the next edge; go to RESP.
- RESP:
  - out_valid is high for exactly one cycle, then return to IDLE; in_ready is high the following cycle.
  - Writeback accepts unconditionally; there is no downstream back-pressure.
- Latency, accept edge to out_valid:
  - Non-memory op: 1 cycle.
  - Memory op: (ack cycles + 1).
  - Throughput: 1 instruction per 2 cycles minimum.
- Writeback fields:
  - wb_reg_write = reg_write and not is_store.
  - wb_rd_addr is the latched rd_addr.
  - wb_rd_addr = 0 forces wb_reg_write = 0.
- Store lanes (off = addr[1:0]):
  - Byte: wstrb = 0001 << off; wdata = {4{w_data[7:0]}}.
  - Half: wstrb = off[1] ? 1100 : 0011; wdata = {2{w_data[15:0]}}.
  - Word: wstrb = 1111; wdata = w_data.
- Load: shifted = rdata >> (8*off); then extend bit 7 (byte) or bit 15 (half) per is_load_unsigned; word passes through.
- Misalignment definition: half with off[0] = 1, or word with off != 00.
- Width 11 behaves exactly as 10.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN
- Defined:
  - A misaligned load or store issues no bus request; goes IDLE -> RESP directly.
  - misalign = 1 with out_valid; wb_reg_write = 0; wb_data = the faulting address.
- Undefined:
  - misalign is tied 0.
  - Half uses off[1] only; word ignores off.
  - The access proceeds normally with the naturally aligned lanes.

Test Plan:
- Reset mid-BUS: load accepted, dmem_ack withheld, rst_n low -> dmem_req = 0 the same cycle, in_ready = 1, out_valid stays 0; stray ack after release ignored.
- Non-memory op: alu_result = 0x12345678, reg_write = 1, rd = 5 -> out_valid at N+1, wb_data = 0x12345678, wb_rd_addr = 5, dmem_req never high.
- Signed byte load: addr = 0x1003, rdata = 0x80AABBCC, ack after 3 cycles -> dmem_addr = 0x1000, dmem_req high 3 cycles, wb_data = 0xFFFFFF80; same with is_load_unsigned = 1 -> 0x00000080.
- Half store: addr = 0x2002, w_data = 0xDEADBEEF -> dmem_we = 1, wstrb = 1100, wdata = 0xBEEFBEEF, wb_reg_write = 0.
- Zero-wait ack: word load with ack in the first BUS cycle -> out_valid next cycle, in_ready held low 2 cycles total, back-to-back second instruction accepted on the following edge.
- Misaligned word at 0x3001:
  - MEM_MISALIGN_TRAP_EN defined -> no dmem_req, misalign = 1, wb_data = 0x00003001, wb_reg_write = 0.
  - Undefined -> dmem_addr = 0x3000, normal load.
